// File: rtl/genius_pkg.sv
// Shared definitions for the Genius (Simon) sequence controller.
//   state_e    : controller FSM states
//   MAX_LEVEL  : number of rounds needed to win
//   RED..YELLOW: one-hot colour codes as stored in the sequence ROM
package genius_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShowOn,
    StShowOff,
    StWaitIn,
    StWin,
    StLose
  } state_e;

  localparam int unsigned MAX_LEVEL = 16;

  localparam logic [3:0] RED    = 4'b0001;
  localparam logic [3:0] GREEN  = 4'b0010;
  localparam logic [3:0] BLUE   = 4'b0100;
  localparam logic [3:0] YELLOW = 4'b1000;

endpackage

// File: rtl/genius_timer.sv
// Loadable down-counter that saturates at zero.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (has priority over counting)
//   load_val   : value to load
//   zero       : count is currently zero
module genius_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             zero
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/genius_seq_ctrl.sv
// Genius (Simon) game controller: plays back the first `level` colours of an external
// 16-entry one-hot sequence ROM, then checks the player's presses against it.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : single-cycle pulse, starts a new game from IDLE/WIN/LOSE
//   btn        : debounced single-cycle press event (one-hot when non-zero)
//   seq_addr   : registered ROM address (the step index)
//   seq_data   : one-hot ROM colour, combinational on seq_addr
//   led        : colour currently shown
//   level      : current round length (0 when idle, else 1..16)
//   wait_input : player input expected
//   win, lose  : sticky end-of-game indications
module genius_seq_ctrl
  import genius_pkg::*;
#(
  parameter int unsigned ON_CYCLES      = 25_000_000,
  parameter int unsigned OFF_CYCLES     = 12_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] seq_addr,
  input  logic [3:0] seq_data,
  output logic [3:0] led,
  output logic [4:0] level,
  output logic       wait_input,
  output logic       win,
  output logic       lose
);

  localparam int unsigned MaxA   = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned MaxCyc = (MaxA > TIMEOUT_CYCLES) ? MaxA : TIMEOUT_CYCLES;
  localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [TimerW-1:0] OnLoad      = TimerW'(ON_CYCLES - 1);
  localparam logic [TimerW-1:0] OffLoad     = TimerW'(OFF_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLoad = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]        LevelMax    = 5'(MAX_LEVEL);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  level_q, level_d;
  logic        tmr_load;
  logic [TimerW-1:0] tmr_val;
  logic        tmr_zero;
  logic        last_step;

  genius_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // 5-bit compare so idx 15 matches level 16 without wrapping.
  assign last_step = ({1'b0, idx_q} == (level_q - 5'd1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    level_d  = level_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      StIdle, StWin, StLose: begin
        if (start) begin
          level_d  = 5'd1;
          idx_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = OnLoad;
          state_d  = StShowOn;
        end
      end

      StShowOn: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = OffLoad;
          state_d  = StShowOff;
        end
      end

      StShowOff: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (last_step) begin
            idx_d   = '0;
            tmr_val = TimeoutLoad;
            state_d = StWaitIn;
          end else begin
            idx_d   = idx_q + 4'd1;
            tmr_val = OnLoad;
            state_d = StShowOn;
          end
        end
      end

      StWaitIn: begin
        // A press takes priority over a timer that hits zero on the same edge.
        if (btn != '0) begin
          if (btn != seq_data) begin
            state_d = StLose;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = TimeoutLoad;
            if (!last_step) begin
              idx_d = idx_q + 4'd1;
            end else if (level_q < LevelMax) begin
              level_d = level_q + 5'd1;
              idx_d   = '0;
              tmr_val = OnLoad;
              state_d = StShowOn;
            end else begin
              state_d = StWin;
            end
          end
        end else if (tmr_zero) begin
          state_d = StLose;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      level_q <= level_d;
    end
  end

  assign seq_addr   = idx_q;
  assign level      = level_q;
  assign led        = (state_q == StShowOn) ? seq_data : 4'b0000;
  assign wait_input = (state_q == StWaitIn);
  assign win        = (state_q == StWin);
  assign lose       = (state_q == StLose);

endmodule

// File: tb/tb_genius_seq_ctrl.sv
module tb_genius_seq_ctrl;

  localparam int unsigned On      = 4;
  localparam int unsigned Off     = 2;
  localparam int unsigned Timeout = 20;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] btn;
  logic [3:0] seq_addr;
  logic [3:0] seq_data;
  logic [3:0] led;
  logic [4:0] level;
  logic       wait_input;
  logic       win;
  logic       lose;

  logic [3:0] rom [16];
  int total;
  int bad;

  genius_seq_ctrl #(
    .ON_CYCLES      (On),
    .OFF_CYCLES     (Off),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .btn        (btn),
    .seq_addr   (seq_addr),
    .seq_data   (seq_data),
    .led        (led),
    .level      (level),
    .wait_input (wait_input),
    .win        (win),
    .lose       (lose)
  );

  assign seq_data = rom[seq_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    step();
    btn = 4'b0000;
  endtask

  // Called in the first SHOW_ON cycle; returns in the first WAIT_IN cycle.
  task automatic show_round(input int lvl);
    for (int i = 0; i < lvl; i++) begin
      for (int c = 0; c < int'(On); c++) begin
        chk("show_led", 32'(led), 32'(rom[i]));
        chk("show_addr", 32'(seq_addr), i);
        chk("show_level", 32'(level), lvl);
        chk("show_wait", 32'(wait_input), 0);
        step();
      end
      for (int c = 0; c < int'(Off); c++) begin
        chk("gap_led", 32'(led), 0);
        chk("gap_wait", 32'(wait_input), 0);
        step();
      end
    end
    chk("enter_wait", 32'(wait_input), 1);
    chk("enter_wait_addr", 32'(seq_addr), 0);
    chk("enter_wait_led", 32'(led), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 32'(seq_addr), 0);
    chk({tag, "_led"}, 32'(led), 0);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_wait"}, 32'(wait_input), 0);
    chk({tag, "_win"}, 32'(win), 0);
    chk({tag, "_lose"}, 32'(lose), 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rom[0]  = 4'b0001; rom[1]  = 4'b0100; rom[2]  = 4'b0001; rom[3]  = 4'b1000;
    rom[4]  = 4'b0010; rom[5]  = 4'b1000; rom[6]  = 4'b0100; rom[7]  = 4'b0010;
    rom[8]  = 4'b0001; rom[9]  = 4'b0010; rom[10] = 4'b0100; rom[11] = 4'b1000;
    rom[12] = 4'b1000; rom[13] = 4'b0100; rom[14] = 4'b0010; rom[15] = 4'b0001;
    rst_n = 1'b0;
    start = 1'b0;
    btn   = 4'b0000;
    step();
    step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();
    chk_reset_vals("idle");

    // 1. start and first playback
    pulse_start();
    show_round(1);
    chk("l1_level", 32'(level), 1);

    // 2. level advance and two-colour playback
    press(4'b0001);
    chk("adv_level", 32'(level), 2);
    chk("adv_led", 32'(led), 32'(4'b0001));
    show_round(2);

    // 3. wrong press
    press(4'b0001);
    chk("idx_inc", 32'(seq_addr), 1);
    chk("idx_inc_wait", 32'(wait_input), 1);
    press(4'b0010);
    chk("wrong_lose", 32'(lose), 1);
    chk("wrong_level", 32'(level), 2);
    chk("wrong_wait", 32'(wait_input), 0);
    step();
    step();
    chk("lose_sticky", 32'(lose), 1);
    pulse_start();
    chk("restart_level", 32'(level), 1);
    chk("restart_lose", 32'(lose), 0);

    // 4a. timeout: 20 idle cycles in WAIT_IN
    show_round(1);
    repeat (Timeout - 1) step();
    chk("to_still_wait", 32'(wait_input), 1);
    chk("to_not_lose", 32'(lose), 0);
    step();
    chk("to_lose", 32'(lose), 1);

    // 4b. press on the 20th cycle wins over the timeout
    pulse_start();
    show_round(1);
    repeat (Timeout - 1) step();
    press(4'b0001);
    chk("tie_level", 32'(level), 2);
    chk("tie_lose", 32'(lose), 0);
    show_round(2);

    // 4c. timeout counted from the last press
    press(4'b0001);
    repeat (Timeout - 1) step();
    chk("to_press_wait", 32'(wait_input), 1);
    chk("to_press_addr", 32'(seq_addr), 1);
    step();
    chk("to_press_lose", 32'(lose), 1);

    // 4d. multi-hot press
    pulse_start();
    show_round(1);
    press(4'b0011);
    chk("multi_lose", 32'(lose), 1);
    chk("multi_level", 32'(level), 1);

    // 5. win through 16 rounds, start held through one playback
    pulse_start();
    for (int l = 1; l <= 16; l++) begin
      if (l == 5) start = 1'b1;
      show_round(l);
      start = 1'b0;
      for (int i = 0; i < l; i++) begin
        chk("win_addr", 32'(seq_addr), i);
        press(rom[i]);
      end
      if (l < 16) chk("win_next_level", 32'(level), l + 1);
    end
    chk("win_flag", 32'(win), 1);
    chk("win_level", 32'(level), 16);
    chk("win_wait", 32'(wait_input), 0);
    chk("win_led", 32'(led), 0);
    chk("win_lose", 32'(lose), 0);
    press(4'b0001);
    chk("win_sticky", 32'(win), 1);

    // 6a. reset mid-SHOW_ON
    pulse_start();
    step();
    chk("pre_rst_led", 32'(led), 32'(4'b0001));
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_show");
    rst_n = 1'b1;
    repeat (5) step();
    chk_reset_vals("idle_show");

    // 6b. reset mid-WAIT_IN with a non-zero index
    pulse_start();
    show_round(1);
    press(4'b0001);
    show_round(2);
    press(4'b0001);
    chk("pre_rst_addr", 32'(seq_addr), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_wait");
    rst_n = 1'b1;
    repeat (5) step();
    chk_reset_vals("idle_wait");
    pulse_start();
    chk("post_rst_level", 32'(level), 1);
    chk("post_rst_led", 32'(led), 32'(4'b0001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/genius_seq_ctrl.md
# genius_seq_ctrl

Game controller for the Genius (Simon) memory game. Drives the address of the 16-entry one-hot colour sequence ROM, plays back the first `level` colours on the LEDs, then checks the player's button presses against the same ROM entries. The level advances on a fully correct round, up to 16. Sits between the sequence ROM, the debounced button front end and the LED/status outputs.

## Interface
- `ON_CYCLES`, default 25_000_000: cycles each colour is lit during playback (≥1).
- `OFF_CYCLES`, default 12_500_000: dark gap after each playback colour (≥1).
- `TIMEOUT_CYCLES`, default 250_000_000: maximum cycles allowed between presses in the input phase (≥1).
- `clk` in 1: single clock; everything is in this domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a new game.
- `btn` in 4: debounced single-cycle press event. Must be one-hot when non-zero.
- `seq_addr` out 4: registered ROM address.
- `seq_data` in 4: one-hot colour from the ROM. It is combinational on `seq_addr`.
- `led` out 4: colour currently shown.
- `level` out 5: current round length. 0 when idle, otherwise 1..16.
- `wait_input` out 1: high while player input is expected.
- `win` out 1: high after level 16 is completed.
- `lose` out 1: high after a wrong press or a timeout.

## Operation
- **States:** IDLE, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE.
- **Internal registers:**
  - `idx` (4 bit): step within the round. Always drives `seq_addr`.
  - `timer`: down-counter, `$clog2` of the largest parameter.
- **IDLE / WIN / LOSE + `start`:** set `level`=1, `idx`=0, go to SHOW_ON with `timer`=ON_CYCLES-1.
  - `start` is ignored in SHOW_ON, SHOW_OFF and WAIT_IN.
- **SHOW_ON:**
  - `led` = `seq_data`.
  - At `timer`=0, go to SHOW_OFF with `timer`=OFF_CYCLES-1.
- **SHOW_OFF:**
  - `led` = 0.
  - At `timer`=0: if `idx`==`level`-1, set `idx`=0 and go to WAIT_IN with `timer`=TIMEOUT_CYCLES-1.
  - Otherwise `idx`++ and go back to SHOW_ON.
- **WAIT_IN:** `led` = 0 and `wait_input` = 1. `timer` reloads on every press.
  - `btn`==0 and `timer`=0: go to LOSE.
  - `btn`!=`seq_data`, including any non-one-hot value: go to LOSE.
  - Correct press with `idx`<`level`-1: `idx`++.
  - Correct press with `idx`==`level`-1 and `level`<16: `level`++, `idx`=0, go to SHOW_ON. The new round replays from entry 0.
  - Correct press with `level`==16: go to WIN.
- **WIN / LOSE:**
  - These are sticky; only `start` leaves them.
  - `level` holds its last value and `led` = 0.
- **Arithmetic:** `level` is stored as 5 bits. The comparison `idx`==`level`-1 uses 5-bit arithmetic, so `idx`=15 matches `level`=16 with no wrap.
  - `idx` never increments past `level`-1.

## Timing
- **Reset values:** `seq_addr`=0, `led`=0, `level`=0, `wait_input`=0, `win`=0, `lose`=0, state IDLE.
- **Reset mid-operation:** returns to exactly these values immediately (asynchronous).
- **Registered vs decoded:** state, `idx`, `level` and `timer` are registered. `led`, `wait_input`, `win` and `lose` are decoded combinationally from the registered state; `led` additionally depends on `seq_data`.
- **Start latency:** `start` sampled high at edge N → SHOW_ON from cycle N+1.
  - `led` shows ROM[0] for exactly ON_CYCLES cycles.
  - It is then dark for exactly OFF_CYCLES cycles.
- **Press sampling:** a press is sampled on the edge where `btn`!=0. The resulting state or `idx` change is visible the next cycle.
- **Timeout:** with no press, LOSE is entered TIMEOUT_CYCLES cycles after entering WAIT_IN, or after the last press.
- **Simultaneous press and timeout:** a press on the same edge where `timer` reaches 0 is evaluated as a press; the timeout is ignored.

## Structure
- **Package `genius_pkg`:**
  - State enum.
  - `MAX_LEVEL`=16.
  - Colour constants `RED`=4'b0001, `GREEN`=4'b0010, `BLUE`=4'b0100, `YELLOW`=4'b1000.
- **Sub-module `genius_timer`:** a loadable down-counter with `load`, `load_val` and `zero` signals.
- **ROM:** not instantiated inside this block. The top level connects `seq_addr`/`seq_data` to it.

## Test plan
The bench uses a model ROM with entries 0..3 = 0001, 0100, 0001, 1000, and parameters ON=4, OFF=2, TIMEOUT=20.

1. **Start:** pulse `start` → `led`=0001 for 4 cycles, then 0 for 2 cycles → `wait_input`=1, `level`=1.
2. **Level advance:** press 0001 in level 1 → `level`=2. Playback shows `led`=0001 then 0100 at `seq_addr` 0 then 1, each for 4 cycles with 2-cycle gaps.
3. **Wrong press:** in level 2, press 0001 then 0010 → `lose`=1, `level` stays 2. A later `start` → `level`=1, `lose`=0.
4. **Timeout and tie-break:**
   - No press for 20 cycles in WAIT_IN → `lose`=1.
   - A correct press on cycle 20 keeps play going.
   - A multi-hot press (0011) → `lose`=1.
5. **Win:** 16 rounds of correct presses → `win`=1, `level`=16, `wait_input`=0. `start` mid-playback is ignored.
6. **Reset mid-operation:** assert `rst_n` low mid-SHOW_ON and mid-WAIT_IN → all outputs are reset values within the same cycle. Release → remains IDLE until `start`.
